// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default sizing for the UART receive packetizer.
package uart_pkg;

  // One FIFO entry: a received byte plus its end-of-packet marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } uart_beat_t;

  // 1024-entry buffer; 20 bit-times of idle at a 434-clock bit period.
  localparam int unsigned DEF_FIFO_EA     = 10;
  localparam int unsigned DEF_IDLE_CYCLES = 8680;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with a registered first-word-fall-through head.
// The head register is a copy of the oldest stored entry; that entry keeps its slot
// until it is popped, so the FIFO holds exactly 2**EA entries.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned EA = 4,
  parameter type         T  = uart_beat_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  input  T     i_data,
  output logic o_full,
  output logic o_rdy,
  output T     o_data,
  input  logic i_rdy
);

  localparam int unsigned DEPTH   = 1 << EA;
  localparam logic [EA:0] PTR_ONE = (EA + 1)'(1);

  T            r_mem [DEPTH];
  logic [EA:0] r_wptr;
  logic [EA:0] r_rptr;
  logic        r_vld;
  T            r_data;

  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_nxt_vld;
  logic [EA:0] w_rptr_nxt;

  // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
  assign w_full     = (r_wptr[EA] != r_rptr[EA]) && (r_wptr[EA-1:0] == r_rptr[EA-1:0]);
  assign w_pop      = r_vld & i_rdy;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still taken.
  assign w_push     = i_en & (~w_full | w_pop);
  assign w_rptr_nxt = w_pop ? (r_rptr + PTR_ONE) : r_rptr;
  assign w_nxt_vld  = (r_wptr != w_rptr_nxt);

  // Storage array, written only on accepted pushes.
  // NOTE: the memory array has no reset; the pointers alone define which slots hold data.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[EA-1:0]] <= i_data;
  end

  // Write and read pointers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      r_rptr <= w_rptr_nxt;
    end
  end

  // Head register: reloads the oldest unpopped slot each cycle, which keeps it stable
  // during a stall and advances it by one entry per pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      r_vld <= w_nxt_vld;
      if (w_nxt_vld) r_data <= r_mem[w_rptr_nxt[EA-1:0]];
    end
  end

  assign o_full = w_full;
  assign o_rdy  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/uart_rx_packetizer.sv
// uart_rx_packetizer: turns the uart_rx byte strobe into an AXI-Stream byte stream.
// The newest byte waits in a pending register until either another byte arrives
// (it is queued with last=0) or the line stays idle long enough (queued with last=1).
module uart_rx_packetizer
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_EA     = DEF_FIFO_EA,
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  input  logic       o_tready,
  output logic       o_tvalid,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_overflow
);

  localparam int unsigned   CW       = $clog2(IDLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_pend_vld;
  logic [7:0]    r_pend_data;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  logic          w_timeout;
  logic          w_push;
  logic          w_full;
  logic          w_out_vld;
  uart_beat_t    w_beat;
  uart_beat_t    w_out;

  // A new strobe always wins over a coincident timeout: the byte is then not a packet end.
  assign w_timeout = ~rx_en & r_pend_vld & (r_cnt == CNT_LAST);
  assign w_push    = (rx_en & r_pend_vld) | w_timeout;
  assign w_beat    = '{last: w_timeout, data: r_pend_data};

  // Pending byte and idle timer; the timer only runs while a byte is pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_cnt       <= '0;
    end else if (rx_en) begin
      r_pend_vld  <= 1'b1;
      r_pend_data <= rx_data;
      r_cnt       <= '0;
    end else if (r_pend_vld) begin
      if (w_timeout) begin
        r_pend_vld <= 1'b0;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Overflow pulse: a push arrived while the FIFO was full and no pop freed a slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_ovf <= 1'b0;
    else       r_ovf <= w_push & w_full & ~(w_out_vld & o_tready);
  end

  uart_sync_fifo #(
    .EA (FIFO_EA),
    .T  (uart_beat_t)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (w_push),
    .i_data (w_beat),
    .o_full (w_full),
    .o_rdy  (w_out_vld),
    .o_data (w_out),
    .i_rdy  (o_tready)
  );

  assign o_tvalid   = w_out_vld;
  assign o_tdata    = w_out.data;
  assign o_tlast    = w_out.last;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Bench for uart_rx_packetizer. Two instances share clock and reset: dut_a (FIFO_EA=2)
// takes the directed cases, dut_r (FIFO_EA=4) takes a long random run. Stimulus pushes the
// expected {last,data} beats into a queue; a monitor per instance pops on each handshake.
module tb_uart_rx_packetizer;

  localparam int IDLE = 16;
  localparam int NRND = 2000;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rx_data_a, rx_data_r;
  logic       rx_en_a, rx_en_r;
  logic       tready_a, tready_r;
  logic       tvalid_a, tvalid_r;
  logic [7:0] tdata_a, tdata_r;
  logic       tlast_a, tlast_r;
  logic       ovf_a, ovf_r;

  logic [8:0] q_a[$];
  logic [8:0] q_r[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt_a = 0, ovf_cnt_r = 0;
  int beats_a = 0, beats_r = 0;

  always #5 clk = ~clk;

  uart_rx_packetizer #(.FIFO_EA(2), .IDLE_CYCLES(IDLE)) dut_a (
    .clk(clk), .rstn(rstn), .rx_data(rx_data_a), .rx_en(rx_en_a), .o_tready(tready_a),
    .o_tvalid(tvalid_a), .o_tdata(tdata_a), .o_tlast(tlast_a), .o_overflow(ovf_a)
  );

  uart_rx_packetizer #(.FIFO_EA(4), .IDLE_CYCLES(IDLE)) dut_r (
    .clk(clk), .rstn(rstn), .rx_data(rx_data_r), .rx_en(rx_en_r), .o_tready(tready_r),
    .o_tvalid(tvalid_r), .o_tdata(tdata_r), .o_tlast(tlast_r), .o_overflow(ovf_r)
  );

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All stimulus runs 1 ns after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle strobe, sampled at the next rising edge.
  task automatic send(input bit to_r, input logic [7:0] d);
    if (to_r) begin rx_en_r = 1'b1; rx_data_r = d; end
    else      begin rx_en_a = 1'b1; rx_data_a = d; end
    step(1);
    rx_en_a = 1'b0;
    rx_en_r = 1'b0;
  endtask

  task automatic drain_a(input string name);
    for (int j = 0; j < 300 && q_a.size() != 0; j++) step(1);
    check(q_a.size() == 0, name, q_a.size(), 0);
  endtask

  // Monitor for dut_a: handshake scoreboard, stall stability, overflow pulse count.
  initial begin : mon_a
    logic [8:0] held;
    logic [8:0] exp;
    bit         held_vld;
    held_vld = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held_vld = 1'b0;
      end else begin
        if (held_vld)
          check({tvalid_a, tlast_a, tdata_a} == {1'b1, held}, "a_stall_hold",
                {tvalid_a, tlast_a, tdata_a}, {1'b1, held});
        if (tvalid_a && tready_a) begin
          beats_a++;
          check(q_a.size() != 0, "a_unexpected_beat", {tlast_a, tdata_a}, 0);
          if (q_a.size() != 0) begin
            exp = q_a.pop_front();
            check({tlast_a, tdata_a} == exp, "a_beat", {tlast_a, tdata_a}, exp);
          end
        end
        held_vld = tvalid_a && !tready_a;
        held     = {tlast_a, tdata_a};
        if (ovf_a) ovf_cnt_a++;
      end
    end
  end

  // Monitor for dut_r.
  initial begin : mon_r
    logic [8:0] held;
    logic [8:0] exp;
    bit         held_vld;
    held_vld = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held_vld = 1'b0;
      end else begin
        if (held_vld)
          check({tvalid_r, tlast_r, tdata_r} == {1'b1, held}, "r_stall_hold",
                {tvalid_r, tlast_r, tdata_r}, {1'b1, held});
        if (tvalid_r && tready_r) begin
          beats_r++;
          check(q_r.size() != 0, "r_unexpected_beat", {tlast_r, tdata_r}, 0);
          if (q_r.size() != 0) begin
            exp = q_r.pop_front();
            check({tlast_r, tdata_r} == exp, "r_beat", {tlast_r, tdata_r}, exp);
          end
        end
        held_vld = tvalid_r && !tready_r;
        held     = {tlast_r, tdata_r};
        if (ovf_r) ovf_cnt_r++;
      end
    end
  end

  // Random sink readiness for dut_r (ready three cycles in four).
  initial begin : rdy_r
    tready_r = 1'b0;
    forever begin
      @(posedge clk);
      #1 tready_r = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : stim
    int          lat;
    int          ovf0;
    int          beats0;
    int          g;
    logic [7:0]  d;
    logic [7:0]  seq3 [6];
    logic [7:0]  seq1 [3];

    rstn = 1'b1;
    rx_en_a = 1'b0; rx_data_a = '0;
    rx_en_r = 1'b0; rx_data_r = '0;
    tready_a = 1'b0;
    #3 rstn = 1'b0;
    step(3);
    check(tvalid_a == 1'b0, "reset_tvalid", tvalid_a, 0);
    check(tdata_a == 8'h00, "reset_tdata", tdata_a, 0);
    check(tlast_a == 1'b0, "reset_tlast", tlast_a, 0);
    check(ovf_a == 1'b0, "reset_overflow", ovf_a, 0);
    rstn = 1'b1;
    step(2);

    // 1: three bytes at 4-clock spacing, last one closes the packet 17 clocks after its strobe.
    tready_a = 1'b1;
    ovf0 = ovf_cnt_a;
    seq1[0] = 8'h41; seq1[1] = 8'h42; seq1[2] = 8'h43;
    q_a.push_back({1'b0, 8'h41});
    q_a.push_back({1'b0, 8'h42});
    q_a.push_back({1'b1, 8'h43});
    for (int i = 0; i < 3; i++) begin
      send(1'b0, seq1[i]);
      if (i < 2) step(3);
    end
    lat = 0;
    for (int j = 1; j <= 40 && lat == 0; j++) begin
      step(1);
      if (tvalid_a && tdata_a == 8'h43) lat = j;
    end
    check(lat == 17, "t1_last_latency", lat, 17);
    step(30);
    drain_a("t1_drain");
    check(ovf_cnt_a == ovf0, "t1_no_overflow", ovf_cnt_a - ovf0, 0);

    // 2: single byte forms a one-beat packet.
    ovf0   = ovf_cnt_a;
    beats0 = beats_a;
    q_a.push_back({1'b1, 8'h5A});
    send(1'b0, 8'h5A);
    step(30);
    drain_a("t2_drain");
    check(beats_a - beats0 == 1, "t2_beat_count", beats_a - beats0, 1);
    check(ovf_cnt_a == ovf0, "t2_no_overflow", ovf_cnt_a - ovf0, 0);

    // 3: stalled sink, six bytes into a four-entry FIFO. 0x00..0x03 are queued with last=0
    // (each closed by the next strobe); the 0x04 push and the 0x05/last push are both dropped,
    // so the packet boundary is lost and the next byte continues the same packet.
    tready_a = 1'b0;
    ovf0 = ovf_cnt_a;
    for (int i = 0; i < 6; i++) seq3[i] = 8'(i);
    for (int i = 0; i < 4; i++) q_a.push_back({1'b0, seq3[i]});
    for (int i = 0; i < 6; i++) begin
      send(1'b0, seq3[i]);
      step(3);
    end
    step(30);
    check(ovf_cnt_a - ovf0 == 2, "t3_overflow_pulses", ovf_cnt_a - ovf0, 2);
    check(tvalid_a && tdata_a == 8'h00, "t3_head_held", {tvalid_a, tdata_a}, 9'h100);
    tready_a = 1'b1;
    lat = 0;
    for (int j = 1; j <= 20 && lat == 0; j++) begin
      step(1);
      if (q_a.size() == 0) lat = j;
    end
    check(lat == 4, "t3_full_throughput", lat, 4);
    q_a.push_back({1'b1, 8'h77});
    send(1'b0, 8'h77);
    step(30);
    drain_a("t3_drain");

    // 4: strobe exactly at the terminal idle count keeps the packet together;
    // one clock later splits it.
    q_a.push_back({1'b0, 8'hA1});
    q_a.push_back({1'b1, 8'hA2});
    send(1'b0, 8'hA1);
    step(IDLE - 1);
    send(1'b0, 8'hA2);
    step(30);
    drain_a("t4_no_split");
    q_a.push_back({1'b1, 8'hB1});
    q_a.push_back({1'b1, 8'hB2});
    send(1'b0, 8'hB1);
    step(IDLE);
    send(1'b0, 8'hB2);
    step(30);
    drain_a("t4_split");

    // 5: reset mid-packet discards the queued and pending bytes.
    tready_a = 1'b0;
    send(1'b0, 8'h11);
    step(3);
    send(1'b0, 8'h22);
    step(3);
    check(tvalid_a == 1'b1, "t5_pre_reset_valid", tvalid_a, 1);
    rstn = 1'b0;
    #1;
    check(tvalid_a == 1'b0, "t5_reset_tvalid", tvalid_a, 0);
    check(tdata_a == 8'h00, "t5_reset_tdata", tdata_a, 0);
    check(tlast_a == 1'b0, "t5_reset_tlast", tlast_a, 0);
    check(ovf_a == 1'b0, "t5_reset_overflow", ovf_a, 0);
    step(2);
    rstn = 1'b1;
    tready_a = 1'b1;
    beats0 = beats_a;
    step(40);
    check(beats_a == beats0, "t5_no_stale_beats", beats_a - beats0, 0);
    q_a.push_back({1'b1, 8'h33});
    send(1'b0, 8'h33);
    step(30);
    drain_a("t5_drain");

    // 6: random gaps against random readiness on the deeper instance.
    ovf0 = ovf_cnt_r;
    beats0 = beats_r;
    for (int i = 0; i < NRND; i++) begin
      d = 8'($urandom_range(0, 255));
      g = (i == NRND - 1) ? 40 : int'($urandom_range(2, 24));
      q_r.push_back({(g >= IDLE), d});
      send(1'b1, d);
      step(g);
    end
    for (int j = 0; j < 500 && q_r.size() != 0; j++) step(1);
    check(q_r.size() == 0, "t6_drain", q_r.size(), 0);
    check(beats_r - beats0 == NRND, "t6_beat_count", beats_r - beats0, NRND);
    check(ovf_cnt_r == ovf0, "t6_no_overflow", ovf_cnt_r - ovf0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
